lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store controller: byte/half/word accesses to a 32-bit word memory with sign/zero extension.
// Optional macro LSU_MISALIGN_EN splits misaligned accesses; otherwise they complete with resp_err.
module lsu_ctrl #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic [ADDR_W-3:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              mem_we,
  output logic [2:0]        mem_wr_strb,
  output logic [2:0]        dbg_state
);

  localparam int WA = ADDR_W - 2;

`ifdef LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse in RESP.
  typedef enum logic [2:0] {IDLE, RD0, RD1, WR, RESP} state_t;

  state_t          state_q, state_d;
  logic            we_q, uns_q, err_q, mis_q;
  logic [1:0]      size_q, off_q, k_q, last_k;
  logic [WA-1:0]   word_q, word_nxt;
  logic [31:0]     wdata_q, w0_q, w1_q, ld, ext;
  logic [63:0]     cat;
  logic [2:0]      pos;
  logic            req_mis, req_bad;

  assign req_mis = (req_size == 2'b01 && req_addr[1:0] == 2'b11) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign req_bad = (req_size == 2'b11) || (req_mis && !MIS_EN);

  // Word N+1 wraps modulo DEPTH even when DEPTH is not a power of two.
  assign word_nxt = (word_q == WA'(DEPTH - 1)) ? '0 : word_q + 1'b1;
  assign last_k   = (size_q == 2'b01) ? 2'd1 : 2'd3;
  assign pos      = {1'b0, off_q} + {1'b0, k_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = req_bad ? RESP : (req_we ? WR : RD0);
      RD0:  state_d = mis_q ? RD1 : RESP;
      RD1:  state_d = RESP;
      WR:   state_d = (!mis_q || k_q == last_k) ? RESP : WR;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      k_q     <= 2'b00;
      word_q  <= '0;
      wdata_q <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          err_q   <= req_bad;
          mis_q   <= req_mis;
          size_q  <= req_size;
          off_q   <= req_addr[1:0];
          word_q  <= req_addr[ADDR_W-1:2];
          wdata_q <= req_wdata;
          k_q     <= 2'b00;
          w0_q    <= '0;
          w1_q    <= '0;
        end
        RD0: w0_q <= mem_rd_data;
        RD1: w1_q <= mem_rd_data;
        WR:  k_q  <= k_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Load alignment: the two captured words form a 64-bit window shifted by the byte offset.
  assign cat = {w1_q, w0_q};
  assign ld  = cat[{off_q, 3'b000} +: 32];

  always_comb begin
    case (size_q)
      2'b00:   ext = uns_q ? {24'b0, ld[7:0]}  : {{24{ld[7]}}, ld[7:0]};
      2'b01:   ext = uns_q ? {16'b0, ld[15:0]} : {{16{ld[15]}}, ld[15:0]};
      default: ext = ld;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == IDLE);
    resp_valid  = (state_q == RESP);
    resp_err    = (state_q == RESP) && err_q;
    resp_rdata  = (state_q == RESP && !err_q && !we_q) ? ext : 32'b0;
    mem_rd_addr = '0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_wr_strb = 3'b000;
    mem_we      = 1'b0;
    case (state_q)
      RD0: mem_rd_addr = word_q;
      RD1: mem_rd_addr = word_nxt;
      WR: begin
        mem_we = 1'b1;
        if (mis_q) begin
          // One byte per cycle; crossing byte lane 3 moves to the next word.
          mem_wr_addr = pos[2] ? word_nxt : word_q;
          mem_wr_strb = {1'b1, pos[1:0]};
          mem_wr_data = {24'b0, wdata_q[{k_q, 3'b000} +: 8]};
        end else begin
          mem_wr_addr = word_q;
          case (size_q)
            2'b00: begin
              mem_wr_strb = {1'b1, off_q};
              mem_wr_data = {24'b0, wdata_q[7:0]};
            end
            2'b01: begin
              mem_wr_strb = off_q[1] ? 3'b011 : 3'b001;
              mem_wr_data = {16'b0, wdata_q[15:0]};
            end
            default: begin
              mem_wr_strb = 3'b000;
              mem_wr_data = wdata_q;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: behavioural word memory, write-log scoreboard, immediate assertions.
// Misaligned expectations follow LSU_MISALIGN_EN when defined.
module tb_lsu_ctrl;
  localparam int DEPTH = 128;
  localparam int AW    = 9;
  localparam int WA    = AW - 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready, resp_valid, resp_err, mem_we;
  logic [31:0]   resp_rdata, mem_rd_data, mem_wr_data;
  logic [WA-1:0] mem_rd_addr, mem_wr_addr;
  logic [2:0]    mem_wr_strb, dbg_state;

  logic [31:0]   mem [0:DEPTH-1];
  logic [9:0]    wr_q[$];
  logic [9:0]    exp_q[$];
  int            n_asrt = 0;
  int            n_fail = 0;

  lsu_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_we(mem_we), .mem_wr_strb(mem_wr_strb), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  assign mem_rd_data = mem[mem_rd_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      wr_q.push_back({mem_wr_addr, mem_wr_strb});
      case (mem_wr_strb)
        3'b000:  mem[mem_wr_addr] = mem_wr_data;
        3'b001:  mem[mem_wr_addr][15:0] = mem_wr_data[15:0];
        3'b011:  mem[mem_wr_addr][31:16] = mem_wr_data[15:0];
        default: mem[mem_wr_addr][8*mem_wr_strb[1:0] +: 8] = mem_wr_data[7:0];
      endcase
    end
  end

  // Scoreboard helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag);
    check({tag, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), {22'b0, wr_q[i]}, {22'b0, exp_q[i]});
    exp_q.delete();
    wr_q.delete();
  endtask

  // Driver: issue one request, scramble req_* while busy, time the response.
  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [AW-1:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
    int lat = 0;
    logic [31:0] rd = '0;
    logic er = 1'b0;
    wr_q.delete();
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
      req_addr = AW'($urandom_range(0, 511));
      req_wdata = $urandom;
      req_size = 2'($urandom_range(0, 3));
      req_we = 1'($urandom_range(0, 1));
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, {31'b0, er}, {31'b0, exp_er});
    @(negedge clk);
    check({tag, "_pulse"}, {30'b0, resp_valid, req_ready}, 32'd1);
    check_wr(tag);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_we_strb", {28'b0, mem_we, mem_wr_strb}, 32'd0);
    check("rst_wr_addr", {25'b0, mem_wr_addr}, 32'd0);
    check("rst_wr_data", mem_wr_data, 32'd0);
    check("rst_rd_addr", {25'b0, mem_rd_addr}, 32'd0);
    rst = 1'b1;

    // Aligned word store and load
    exp_q.push_back({7'd2, 3'b000});
    txn("sw08", 1, 2'b10, 0, 9'h008, 32'hDEADBEEF, 32'h0, 0, 2);
    txn("lw08", 0, 2'b10, 0, 9'h008, 32'h0, 32'hDEADBEEF, 0, 2);

    // Byte/half loads with extension
    mem[3] = 32'h80FF7F01;
    txn("lb0d",  0, 2'b00, 0, 9'h00D, 32'h0, 32'h0000007F, 0, 2);
    txn("lb0e",  0, 2'b00, 0, 9'h00E, 32'h0, 32'hFFFFFFFF, 0, 2);
    txn("lbu0f", 0, 2'b00, 1, 9'h00F, 32'h0, 32'h00000080, 0, 2);
    txn("lh0e",  0, 2'b01, 0, 9'h00E, 32'h0, 32'hFFFF80FF, 0, 2);
    txn("lhu0e", 0, 2'b01, 1, 9'h00E, 32'h0, 32'h000080FF, 0, 2);
    txn("lh0d",  0, 2'b01, 0, 9'h00D, 32'h0, 32'hFFFFFF7F, 0, 2);

    // Aligned half/byte stores
    exp_q.push_back({7'd2, 3'b011});
    txn("sh0a", 1, 2'b01, 0, 9'h00A, 32'h5A5A1234, 32'h0, 0, 2);
    txn("lw08b", 0, 2'b10, 0, 9'h008, 32'h0, 32'h1234BEEF, 0, 2);
    exp_q.push_back({7'd2, 3'b111});
    txn("sb0b", 1, 2'b00, 0, 9'h00B, 32'hFFFFFF99, 32'h0, 0, 2);
    txn("lhu0a", 0, 2'b01, 1, 9'h00A, 32'h0, 32'h00009934, 0, 2);
    txn("lh08",  0, 2'b01, 0, 9'h008, 32'h0, 32'hFFFFBEEF, 0, 2);
    txn("lb09",  0, 2'b00, 0, 9'h009, 32'h0, 32'hFFFFFFBE, 0, 2);
    exp_q.push_back({7'd5, 3'b000});
    txn("sw14", 1, 2'b10, 0, 9'h014, 32'h0BADF00D, 32'h0, 0, 2);
    check("mem5", mem[5], 32'h0BADF00D);

    // Illegal size
    txn("ld_sz3", 0, 2'b11, 0, 9'h008, 32'h0, 32'h0, 1, 1);
    txn("st_sz3", 1, 2'b11, 0, 9'h008, 32'h12345678, 32'h0, 1, 1);
    check("sz3_mem2", mem[2], 32'h9934BEEF);

    // Misaligned accesses
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
`ifdef LSU_MISALIGN_EN
    txn("lw01", 0, 2'b10, 0, 9'h001, 32'h0, 32'h55443322, 0, 3);
    txn("lh03", 0, 2'b01, 0, 9'h003, 32'h0, 32'h00005544, 0, 3);
    mem[1] = 32'h11111111;
    mem[2] = 32'h22222222;
    exp_q.push_back({7'd1, 3'b110});
    exp_q.push_back({7'd1, 3'b111});
    exp_q.push_back({7'd2, 3'b100});
    exp_q.push_back({7'd2, 3'b101});
    txn("sw06", 1, 2'b10, 0, 9'h006, 32'hA1B2C3D4, 32'h0, 0, 5);
    txn("lw04", 0, 2'b10, 0, 9'h004, 32'h0, 32'hC3D41111, 0, 2);
    txn("lw08c", 0, 2'b10, 0, 9'h008, 32'h0, 32'h2222A1B2, 0, 2);
    mem[DEPTH-1] = 32'hAABBCCDD;
    txn("lw_wrap", 0, 2'b10, 0, 9'h1FE, 32'h0, 32'h2211AABB, 0, 3);
    exp_q.push_back({7'd127, 3'b111});
    exp_q.push_back({7'd0, 3'b100});
    txn("sh_wrap", 1, 2'b01, 0, 9'h1FF, 32'h0000BEEF, 32'h0, 0, 3);
    check("wrap_mem0", mem[0], 32'h443322BE);
    check("wrap_mem127", mem[DEPTH-1], 32'hEFBBCCDD);
`else
    txn("lw01_err", 0, 2'b10, 0, 9'h001, 32'h0, 32'h0, 1, 1);
    txn("lh03_err", 0, 2'b01, 0, 9'h003, 32'h0, 32'h0, 1, 1);
    txn("sw06_err", 1, 2'b10, 0, 9'h006, 32'hA1B2C3D4, 32'h0, 1, 1);
    txn("lw1fe_err", 0, 2'b10, 0, 9'h1FE, 32'h0, 32'h0, 1, 1);
    check("mis_mem1", mem[1], 32'h88776655);
`endif

    // Reset in the middle of a store aborts it
    begin
      logic seen = 1'b0;
      mem[1] = 32'h11111111;
      mem[2] = 32'h22222222;
      wr_q.delete();
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
`ifdef LSU_MISALIGN_EN
      req_addr = 9'h006;
`else
      req_addr = 9'h008;
`endif
      req_wdata = 32'hA1B2C3D4;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("abort_wr1", {31'b0, mem_we}, 32'd1);
`ifdef LSU_MISALIGN_EN
      @(negedge clk);
      check("abort_wr2", {31'b0, mem_we}, 32'd1);
`endif
      rst = 1'b0;
      #1;
      check("abort_we", {31'b0, mem_we}, 32'd0);
      check("abort_ready", {31'b0, req_ready}, 32'd1);
      check("abort_strb", {29'b0, mem_wr_strb}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (resp_valid || mem_we) seen = 1'b1;
      end
      check("abort_quiet", {31'b0, seen}, 32'd0);
`ifdef LSU_MISALIGN_EN
      check("abort_nwr", wr_q.size(), 32'd1);
      check("abort_mem1", mem[1], 32'h11D41111);
`else
      check("abort_nwr", wr_q.size(), 32'd0);
      check("abort_mem1", mem[1], 32'h11111111);
`endif
      check("abort_mem2", mem[2], 32'h22222222);
      wr_q.delete();
    end
    txn("lw08_post", 0, 2'b10, 0, 9'h008, 32'h0, 32'h22222222, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
